uart_transceiver: RTL and testbench

Fixed-format 8N1 UART: an independent transmitter and receiver sharing one clock and one reset. The transmitter serialises a byte on a single-cycle start request. The receiver oversamples by clock count, mid-bit samples, and presents each received byte with a one-cycle done strobe. Sits between byte-level logic and the pins; loopback (Tx_o to Rx_i) is a supported configuration.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_transceiver.sv | 213 +++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared frame constants and FSM state types for the 8N1 UART transceiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    StTxIdle,
    StTxStart,
    StTxData,
    StTxStop
  } txState_e;

  typedef enum logic [2:0] {
    StRxIdle,
    StRxStart,
    StRxData,
    StRxStop,
    StRxWaitIdle
  } rxState_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input; resets to the idle (high) level.
module uart_rx_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic Async_i,
  output logic Sync_o
);

  logic [1:0] syncStages_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      syncStages_q <= 2'b11;
    end else begin
      syncStages_q <= {syncStages_q[0], Async_i};
    end
  end

  assign Sync_o = syncStages_q[1];

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART: independent transmitter and mid-bit sampling receiver on one clock.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ = 10_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       TxStart_i,
  input  logic [7:0] TxData_i,
  output logic       TxBusy_o,
  output logic       TxDone_o,
  output logic       Tx_o,
  input  logic       Rx_i,
  output logic [7:0] RxData_o,
  output logic       RxDone_o
);

  localparam int unsigned TICKS_PER_BIT      = CLOCK_HZ / BAUD;
  localparam int unsigned TICKS_PER_HALF_BIT = TICKS_PER_BIT / 2;
  localparam int unsigned CntW               = $clog2(TICKS_PER_BIT);

  localparam logic [CntW-1:0] BitLast  = CntW'(TICKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(TICKS_PER_HALF_BIT - 1);
  localparam logic [2:0]      IdxLast  = 3'(DATA_BITS - 1);

  // ---------------- Transmitter ----------------
  txState_e        txState_q, txState_d;
  logic [CntW-1:0] txCnt_q, txCnt_d;
  logic [2:0]      txIdx_q, txIdx_d;
  logic [7:0]      txShift_q, txShift_d;
  logic            txLine_q, txLine_d;
  logic            txBitEnd;

  assign txBitEnd = (txCnt_q == BitLast);

  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txIdx_d   = txIdx_q;
    txShift_d = txShift_q;
    TxDone_o  = 1'b0;
    unique case (txState_q)
      StTxIdle: begin
        if (TxStart_i) begin
          txState_d = StTxStart;
          txShift_d = TxData_i;
          txCnt_d   = '0;
        end
      end
      StTxStart: begin
        if (txBitEnd) begin
          txState_d = StTxData;
          txCnt_d   = '0;
          txIdx_d   = '0;
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      StTxData: begin
        if (txBitEnd) begin
          txCnt_d   = '0;
          txShift_d = txShift_q >> 1;
          if (txIdx_q == IdxLast) begin
            txState_d = StTxStop;
          end else begin
            txIdx_d = txIdx_q + 1'b1;
          end
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      StTxStop: begin
        if (txBitEnd) begin
          TxDone_o  = 1'b1;
          txState_d = StTxIdle;
          txCnt_d   = '0;
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      default: txState_d = StTxIdle;
    endcase

    // Line level is registered from the next state so Tx_o is glitch-free.
    unique case (txState_d)
      StTxStart: txLine_d = START_BIT;
      StTxData:  txLine_d = txShift_d[0];
      default:   txLine_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      txState_q <= StTxIdle;
      txCnt_q   <= '0;
      txIdx_q   <= '0;
      txShift_q <= '0;
      txLine_q  <= STOP_BIT;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txIdx_q   <= txIdx_d;
      txShift_q <= txShift_d;
      txLine_q  <= txLine_d;
    end
  end

  assign TxBusy_o = (txState_q != StTxIdle);
  assign Tx_o     = txLine_q;

  // ---------------- Receiver ----------------
  logic            rxSync;
  rxState_e        rxState_q, rxState_d;
  logic [CntW-1:0] rxCnt_q, rxCnt_d;
  logic [2:0]      rxIdx_q, rxIdx_d;
  logic [7:0]      rxShift_q, rxShift_d;
  logic [7:0]      rxData_q, rxData_d;
  logic            rxDone_q, rxDone_d;
  logic            rxBitEnd;

  uart_rx_sync u_rx_sync (
    .Clock  (Clock),
    .Reset  (Reset),
    .Async_i(Rx_i),
    .Sync_o (rxSync)
  );

  assign rxBitEnd = (rxCnt_q == BitLast);

  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q;
    rxIdx_d   = rxIdx_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    rxDone_d  = 1'b0;
    unique case (rxState_q)
      StRxIdle: begin
        if (rxSync == START_BIT) begin
          rxState_d = StRxStart;
          rxCnt_d   = '0;
        end
      end
      StRxStart: begin
        // Half a bit in: a line back high means the edge was a glitch.
        if (rxCnt_q == HalfLast) begin
          rxCnt_d   = '0;
          rxIdx_d   = '0;
          rxState_d = (rxSync == START_BIT) ? StRxData : StRxIdle;
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      StRxData: begin
        if (rxBitEnd) begin
          rxCnt_d   = '0;
          rxShift_d = {rxSync, rxShift_q[7:1]};
          if (rxIdx_q == IdxLast) begin
            rxState_d = StRxStop;
          end else begin
            rxIdx_d = rxIdx_q + 1'b1;
          end
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      StRxStop: begin
        if (rxBitEnd) begin
          rxCnt_d = '0;
          if (rxSync == STOP_BIT) begin
            rxData_d  = rxShift_q;
            rxDone_d  = 1'b1;
            rxState_d = StRxIdle;
          end else begin
            rxState_d = StRxWaitIdle;
          end
        end else begin
          rxCnt_d = rxCnt_q + 1'b1;
        end
      end
      StRxWaitIdle: begin
        if (rxSync == STOP_BIT) begin
          rxState_d = StRxIdle;
        end
      end
      default: rxState_d = StRxIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rxState_q <= StRxIdle;
      rxCnt_q   <= '0;
      rxIdx_q   <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      rxDone_q  <= 1'b0;
    end else begin
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxIdx_q   <= rxIdx_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      rxDone_q  <= rxDone_d;
    end
  end

  assign RxData_o = rxData_q;
  assign RxDone_o = rxDone_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed loopback bench for uart_transceiver with a receive-byte scoreboard.
module tb_uart_transceiver;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       TxStart_i;
  logic [7:0] TxData_i;
  logic       TxBusy_o;
  logic       TxDone_o;
  logic       Tx_o;
  logic       Rx_i;
  logic [7:0] RxData_o;
  logic       RxDone_o;

  logic loopMode;
  logic rxDrive;

  int         nAsserts = 0;
  int         nFail    = 0;
  int         rxCount  = 0;
  logic [7:0] expRx[$];

  always #5 Clock = ~Clock;

  assign Rx_i = loopMode ? Tx_o : rxDrive;

  uart_transceiver #(
    .CLOCK_HZ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .TxStart_i(TxStart_i),
    .TxData_i (TxData_i),
    .TxBusy_o (TxBusy_o),
    .TxDone_o (TxDone_o),
    .Tx_o     (Tx_o),
    .Rx_i     (Rx_i),
    .RxData_o (RxData_o),
    .RxDone_o (RxDone_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Scoreboard: every RxDone strobe must match the oldest expected byte.
  always @(negedge Clock) begin
    if (RxDone_o === 1'b1) begin
      rxCount++;
      nAsserts++;
      assert (expRx.size() > 0)
      else begin
        nFail++;
        $error("FAIL rx_spurious: observed RxDone with RxData_o %0h expected no strobe", RxData_o);
      end
      if (expRx.size() > 0) check("rx_data", RxData_o, expRx.pop_front());
    end
  end

  // Sends one byte and checks the full 100-cycle line waveform and TxDone timing.
  task automatic sendFrame(input logic [7:0] d, input bit injectBusy);
    int   doneAt;
    int   nDone;
    int   k;
    logic expBit;
    doneAt = -1;
    nDone  = 0;
    @(negedge Clock);
    TxStart_i = 1'b1;
    TxData_i  = d;
    expRx.push_back(d);
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      TxStart_i = 1'b0;
      TxData_i  = 8'h00;
      if (injectBusy && i == 50) begin
        TxStart_i = 1'b1;
        TxData_i  = 8'h55;
      end
      k = i / 10;
      if (k == 0) expBit = 1'b0;
      else if (k == 9) expBit = 1'b1;
      else expBit = d[k-1];
      check("tx_line", Tx_o, expBit);
      if (TxDone_o === 1'b1) begin
        nDone++;
        if (doneAt < 0) doneAt = i;
      end
      if (i == 0 || i == 99) check("tx_busy", TxBusy_o, 1'b1);
    end
    TxStart_i = 1'b0;
    check("tx_done_time", doneAt, 99);
    check("tx_done_count", nDone, 1);
  endtask

  initial begin
    Reset     = 1'b1;
    TxStart_i = 1'b0;
    TxData_i  = 8'h00;
    loopMode  = 1'b1;
    rxDrive   = 1'b1;
    tick(3);
    check("rst_tx", Tx_o, 1'b1);
    check("rst_busy", TxBusy_o, 1'b0);
    check("rst_txdone", TxDone_o, 1'b0);
    check("rst_rxdata", RxData_o, 8'h00);
    check("rst_rxdone", RxDone_o, 1'b0);
    Reset = 1'b0;
    tick(99);

    // Basic loopback, then a back-to-back frame.
    sendFrame(8'hAB, 1'b0);
    check("ab_count", rxCount, 1);
    check("ab_data", RxData_o, 8'hAB);
    sendFrame(8'hCD, 1'b0);
    check("cd_count", rxCount, 2);
    check("cd_data", RxData_o, 8'hCD);

    // Request while busy must be ignored.
    sendFrame(8'h69, 1'b1);
    tick(30);
    check("ign_tx_idle", Tx_o, 1'b1);
    check("ign_busy", TxBusy_o, 1'b0);
    check("ign_count", rxCount, 3);
    check("ign_data", RxData_o, 8'h69);

    // Short low glitch on the line.
    loopMode = 1'b0;
    tick(5);
    rxDrive = 1'b0;
    tick(3);
    rxDrive = 1'b1;
    tick(50);
    check("glitch_count", rxCount, 3);
    check("glitch_data", RxData_o, 8'h69);
    loopMode = 1'b1;
    sendFrame(8'h3C, 1'b0);
    check("3c_count", rxCount, 4);
    check("3c_data", RxData_o, 8'h3C);

    // Framing error: 8'hFF with a low stop bit, line held low afterwards.
    loopMode = 1'b0;
    for (int b = 0; b < 10; b++) begin
      rxDrive = (b >= 1 && b <= 8) ? 1'b1 : 1'b0;
      tick(10);
    end
    tick(20);
    check("ferr_count", rxCount, 4);
    check("ferr_data", RxData_o, 8'h3C);
    rxDrive = 1'b1;
    tick(20);
    loopMode = 1'b1;
    sendFrame(8'h12, 1'b0);
    check("12_count", rxCount, 5);
    check("12_data", RxData_o, 8'h12);

    // Reset in the middle of a frame on both sides.
    @(negedge Clock);
    TxStart_i = 1'b1;
    TxData_i  = 8'h77;
    @(negedge Clock);
    TxStart_i = 1'b0;
    tick(40);
    check("mid_busy", TxBusy_o, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    check("mrst_tx", Tx_o, 1'b1);
    check("mrst_busy", TxBusy_o, 1'b0);
    check("mrst_rxdata", RxData_o, 8'h00);
    check("mrst_rxdone", RxDone_o, 1'b0);
    tick(1);
    Reset = 1'b0;
    tick(20);
    check("post_rst_count", rxCount, 5);
    check("post_rst_data", RxData_o, 8'h00);
    sendFrame(8'hA5, 1'b0);
    check("a5_count", rxCount, 6);
    check("a5_data", RxData_o, 8'hA5);
    tick(20);
    check("queue_empty", expRx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
